// File: rtl/mau_pkg.sv
// Shared types and constants for the MAU result buffer.
// mau_res_fifo has one build option, MAU_RES_FIFO_HWM_EN, which adds a high-water-mark output.
package mau_pkg;

    // Width of an ALU result word (matches the ALU res_q register).
    localparam int RES_W      = 10;

    // Default number of result buffer entries (power of two, at least 2).
    localparam int FIFO_DEPTH = 4;

    // One queued result: the carry sits in the MSB above the data.
    typedef struct packed {
        logic             carry;
        logic [RES_W-1:0] data;
    } res_word_t;

endpackage : mau_pkg

// File: rtl/mau_res_mem.sv
// DEPTH-entry register array for the MAU result buffer.
// It has one synchronous write port and one asynchronous read port.
// The storage is never reset. The FIFO masks the read data while it holds no valid entry.
module mau_res_mem
    import mau_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  res_word_t     wdata,
    input  logic [AW-1:0] raddr,
    output res_word_t     rdata
);

    res_word_t mem_r [DEPTH];

    // Store the incoming word at the write address on an accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule : mau_res_mem

// File: rtl/mau_res_fifo.sv
// This is the result buffer between alu_stage_4b and tx_4b in the 4-bit MAU.
// It queues {carry, result} words from the ALU and shows the head word to TX first-word-fall-through.
// Pointers carry an extra wrap bit, so full and empty can be told apart without a separate counter.
// in_ready depends only on registered state, so there is no combinational path from TX back to the ALU.
// Build option MAU_RES_FIFO_HWM_EN adds the hwm output. hwm is the peak occupancy since the last reset or flush.
module mau_res_fifo
    import mau_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int RES_W = mau_pkg::RES_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [RES_W-1:0]         in_data,
    input  logic                     in_carry,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RES_W-1:0]         out_data,
    output logic                     out_carry,
    output logic [$clog2(DEPTH):0]   count,
`ifdef MAU_RES_FIFO_HWM_EN
    output logic [$clog2(DEPTH):0]   hwm,
`endif
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic          overflow_r;
    logic [PW-1:0] wr_nxt_s;
    logic [PW-1:0] rd_nxt_s;
    logic          overflow_nxt_s;
    logic          empty_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;
    res_word_t     wdata_s;
    res_word_t     rdata_s;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) &&
                     (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]);

    // A flush cycle writes nothing into storage, so a word presented with flush is really dropped.
    assign push_s  = in_valid & ~full_s & ~flush;
    assign pop_s   = ~empty_s & out_ready;

    assign wdata_s = '{carry: in_carry, data: in_data};

    mau_res_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata (wdata_s),
        .raddr (rd_ptr_r[AW-1:0]),
        .rdata (rdata_s)
    );

    // Compute next pointer and overflow state. Flush takes priority over push, pop and overflow.
    always_comb begin
        wr_nxt_s       = wr_ptr_r;
        rd_nxt_s       = rd_ptr_r;
        overflow_nxt_s = overflow_r;
        if (flush) begin
            wr_nxt_s       = PTR_ZERO;
            rd_nxt_s       = PTR_ZERO;
            overflow_nxt_s = 1'b0;
        end else begin
            if (push_s) begin
                wr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_nxt_s = rd_ptr_r;
            end
            if (in_valid && full_s) begin
                overflow_nxt_s = 1'b1;
            end else begin
                overflow_nxt_s = overflow_r;
            end
        end
    end

    // Pointer and sticky-overflow registers. Reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            overflow_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_nxt_s;
            rd_ptr_r   <= rd_nxt_s;
            overflow_r <= overflow_nxt_s;
        end
    end

    // Head word presented to TX. It is forced to zero while the FIFO is empty.
    always_comb begin
        out_data  = {RES_W{1'b0}};
        out_carry = 1'b0;
        if (!empty_s) begin
            out_data  = rdata_s.data;
            out_carry = rdata_s.carry;
        end else begin
            out_data  = {RES_W{1'b0}};
            out_carry = 1'b0;
        end
    end

    assign in_ready  = ~full_s;
    assign out_valid = ~empty_s;
    assign count     = wr_ptr_r - rd_ptr_r;
    assign overflow  = overflow_r;

`ifdef MAU_RES_FIFO_HWM_EN
    logic [PW-1:0] hwm_r;
    logic [PW-1:0] count_nxt_s;

    assign count_nxt_s = wr_nxt_s - rd_nxt_s;

    // Track the largest occupancy seen since the last reset or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_r <= PTR_ZERO;
        end else if (flush) begin
            hwm_r <= PTR_ZERO;
        end else if (count_nxt_s > hwm_r) begin
            hwm_r <= count_nxt_s;
        end else begin
            hwm_r <= hwm_r;
        end
    end

    assign hwm = hwm_r;
`endif

endmodule : mau_res_fifo

// File: tb/tb_mau_res_fifo.sv
// Self-checking bench for mau_res_fifo.
// It has four parts: a table of hand-computed vectors, two hand-written corner sequences,
// and a randomized run checked against a queue-based reference model.
module tb_mau_res_fifo;

    localparam int DEPTH = 4;
    localparam int RES_W = 10;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [RES_W-1:0] in_data;
    logic             in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_data;
    logic             out_carry;
    logic [CW-1:0]    count;
    logic             overflow;
`ifdef MAU_RES_FIFO_HWM_EN
    logic [CW-1:0]    hwm;
`endif

    int checks   = 0;
    int failures = 0;

    mau_res_fifo #(.DEPTH(DEPTH), .RES_W(RES_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .count     (count),
`ifdef MAU_RES_FIFO_HWM_EN
        .hwm       (hwm),
`endif
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input int v, input int d, input int c,
                            input int n, input int r, input int o);
        chk({tag, ".out_valid"}, int'(out_valid), v);
        chk({tag, ".out_data"},  int'(out_data),  d);
        chk({tag, ".out_carry"}, int'(out_carry), c);
        chk({tag, ".count"},     int'(count),     n);
        chk({tag, ".in_ready"},  int'(in_ready),  r);
        chk({tag, ".overflow"},  int'(overflow),  o);
    endtask

    task automatic drive(input logic iv, input logic [RES_W-1:0] d, input logic c,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        in_carry  = c;
        out_ready = ordy;
        flush     = fl;
    endtask

    // One table row: the inputs held for one edge, then the outputs expected after that edge.
    typedef struct {
        logic             iv;
        logic [RES_W-1:0] d;
        logic             c;
        logic             ordy;
        logic             fl;
        int               e_valid;
        int               e_data;
        int               e_carry;
        int               e_count;
        int               e_ready;
        int               e_ovf;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic iv, input int d, input logic c, input logic ordy,
                                input logic fl, input int ev, input int ed, input int ec,
                                input int en, input int er, input int eo);
        vec_t t;
        t.iv = iv; t.d = RES_W'(d); t.c = c; t.ordy = ordy; t.fl = fl;
        t.e_valid = ev; t.e_data = ed; t.e_carry = ec;
        t.e_count = en; t.e_ready = er; t.e_ovf = eo;
        return t;
    endfunction

    // Reference model: a queue of {carry, data} words plus a sticky overflow flag.
    logic [RES_W:0] mq [$];
    logic           m_ovf;
    int             m_peak;

    task automatic model_check(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, ".out_valid"}, int'(out_valid), (sz != 0) ? 1 : 0);
        chk({tag, ".in_ready"},  int'(in_ready),  (sz < DEPTH) ? 1 : 0);
        chk({tag, ".count"},     int'(count),     sz);
        chk({tag, ".overflow"},  int'(overflow),  int'(m_ovf));
        chk({tag, ".out_data"},  int'(out_data),  (sz != 0) ? int'(mq[0][RES_W-1:0]) : 0);
        chk({tag, ".out_carry"}, int'(out_carry), (sz != 0) ? int'(mq[0][RES_W]) : 0);
`ifdef MAU_RES_FIFO_HWM_EN
        chk({tag, ".hwm"}, int'(hwm), m_peak);
`endif
    endtask

    task automatic model_step(input logic iv, input logic [RES_W-1:0] d, input logic c,
                              input logic ordy, input logic fl);
        int  sz;
        bit  do_push;
        bit  do_pop;
        sz = mq.size();
        if (fl) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_peak = 0;
        end else begin
            do_push = iv && (sz < DEPTH);
            do_pop  = ordy && (sz > 0);
            if (iv && sz == DEPTH) m_ovf = 1'b1;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({c, d});
            if (mq.size() > m_peak) m_peak = mq.size();
        end
    endtask

    initial begin
        logic             r_iv, r_c, r_ordy, r_fl;
        logic [RES_W-1:0] r_d;

        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Part 1 rows: test-plan sequences with hand-computed expectations.
        vecs.push_back(mk(1, 'h3A5, 1, 0, 0,  1, 'h3A5, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0,     0, 1, 0,  0, 0,     0, 0, 1, 0));
        vecs.push_back(mk(1, 'h001, 1, 0, 0,  1, 'h001, 1, 1, 1, 0));
        vecs.push_back(mk(1, 'h002, 0, 0, 0,  1, 'h001, 1, 2, 1, 0));
        vecs.push_back(mk(1, 'h003, 1, 0, 0,  1, 'h001, 1, 3, 1, 0));
        vecs.push_back(mk(1, 'h004, 0, 0, 0,  1, 'h001, 1, 4, 0, 0));
        vecs.push_back(mk(1, 'h005, 1, 0, 0,  1, 'h001, 1, 4, 0, 1));
        vecs.push_back(mk(0, 0,     0, 1, 0,  1, 'h002, 0, 3, 1, 1));
        vecs.push_back(mk(0, 0,     0, 1, 0,  1, 'h003, 1, 2, 1, 1));
        vecs.push_back(mk(0, 0,     0, 1, 0,  1, 'h004, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0,     0, 1, 0,  0, 0,     0, 0, 1, 1));
        // Fill the FIFO, then flush with in_valid and out_ready also set.
        vecs.push_back(mk(1, 'h010, 0, 0, 0,  1, 'h010, 0, 1, 1, 1));
        vecs.push_back(mk(1, 'h011, 1, 0, 0,  1, 'h010, 0, 2, 1, 1));
        vecs.push_back(mk(1, 'h012, 0, 0, 0,  1, 'h010, 0, 3, 1, 1));
        vecs.push_back(mk(1, 'h013, 1, 0, 0,  1, 'h010, 0, 4, 0, 1));
        vecs.push_back(mk(1, 'h3FF, 1, 1, 1,  0, 0,     0, 0, 1, 0));
        vecs.push_back(mk(0, 0,     0, 1, 0,  0, 0,     0, 0, 1, 0));
        // Full with out_ready: the pop happens, the push is refused and overflow is set.
        vecs.push_back(mk(1, 'h020, 0, 0, 0,  1, 'h020, 0, 1, 1, 0));
        vecs.push_back(mk(1, 'h021, 1, 0, 0,  1, 'h020, 0, 2, 1, 0));
        vecs.push_back(mk(1, 'h022, 0, 0, 0,  1, 'h020, 0, 3, 1, 0));
        vecs.push_back(mk(1, 'h023, 1, 0, 0,  1, 'h020, 0, 4, 0, 0));
        vecs.push_back(mk(1, 'h2AA, 0, 1, 0,  1, 'h021, 1, 3, 1, 1));
        vecs.push_back(mk(1, 'h2BB, 1, 1, 0,  1, 'h022, 0, 3, 1, 1));
        vecs.push_back(mk(0, 0,     0, 1, 0,  1, 'h023, 1, 2, 1, 1));
        vecs.push_back(mk(0, 0,     0, 1, 0,  1, 'h2BB, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0,     0, 1, 0,  0, 0,     0, 0, 1, 1));

        // Check the reset state while reset is held, then again after release.
        #12;
        chk_outs("reset", 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_outs("idle", 0, 0, 0, 0, 1, 0);

        // Part 1: apply the table rows.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].ordy, vecs[i].fl);
            @(posedge clk); #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data, vecs[i].e_carry,
                     vecs[i].e_count, vecs[i].e_ready, vecs[i].e_ovf);
        end

        // Part 2: continuous push and pop of 10 words. The pointers wrap twice.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(1'b1, RES_W'(10'h100 + k), 1'(k), 1'b1, 1'b0);
            @(posedge clk); #1;
            chk($sformatf("stream%0d.count", k), int'(count), 1);
            chk($sformatf("stream%0d.data", k), int'(out_data), 'h100 + k);
            chk($sformatf("stream%0d.carry", k), int'(out_carry), k & 1);
        end
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("stream_end.count", int'(count), 0);

        // Part 3: asynchronous reset with 3 entries queued.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, RES_W'(10'h0C0 + k), 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("pre_rst.count", int'(count), 3);
        rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 10'h155, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_outs("post_rst", 1, 'h155, 0, 1, 1, 0);

        // Part 4: randomized traffic against the reference model. Start from a flush.
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        mq.delete();
        m_ovf  = 1'b0;
        m_peak = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            r_iv   = ($urandom_range(0, 9) < 7);
            r_d    = RES_W'($urandom);
            r_c    = 1'($urandom);
            r_ordy = ($urandom_range(0, 9) < ((n / 100) % 2 == 0 ? 3 : 7));
            r_fl   = ($urandom_range(0, 59) == 0);
            drive(r_iv, r_d, r_c, r_ordy, r_fl);
            #1;
            model_check($sformatf("rnd%0d", n));
            model_step(r_iv, r_d, r_c, r_ordy, r_fl);
        end
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        model_check("rnd_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mau_res_fifo
